// File: rtl/sp1_wrq_pkg.sv
// Shared constants and helpers for the sp1 write-side capture queue.
package sp1_wrq_pkg;

  localparam int unsigned SP1_DW    = 32;
  localparam int unsigned SP1_DEPTH = 4;

  // Occupancy from wrapping pointers; the extra MSB keeps full distinct from empty.
  function automatic logic [31:0] ptr_dist(input logic [31:0] wp, input logic [31:0] rp,
                                           input int unsigned pw);
    logic [31:0] mask;
    mask = (32'd1 << pw) - 32'd1;
    return (wp - rp) & mask;
  endfunction

endpackage

// File: rtl/sp1_ff.sv
// Enabled data register with asynchronous active-high clear; one per queue entry.
module sp1_ff #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sp1_wrq.sv
// Strobe-fed capture FIFO: accepts one word per cycle on wr_en and drains via valid/ready.
module sp1_wrq
  import sp1_wrq_pkg::*;
#(
  parameter int unsigned DW    = SP1_DW,
  parameter int unsigned DEPTH = SP1_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_d,
  output logic          wr_full,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_d,
  output logic [AW:0]   count,
  output logic          ovf
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW:0]   wp, wp_next;
  logic [AW:0]   rp, rp_next;
  logic          ovf_next;
  logic          pop;
  logic          push;
  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    count    = (AW + 1)'(ptr_dist(32'(wp), 32'(rp), AW + 1));
    rd_valid = (count != '0);
    wr_full  = (count == FULL_CNT);
    pop      = rd_valid & rd_ready;
    // A full queue still takes a write when the head leaves in the same cycle.
    push     = wr_en & (~wr_full | pop);
    wp_next  = push ? wp + 1'b1 : wp;
    rp_next  = pop ? rp + 1'b1 : rp;
    ovf_next = ovf | (wr_en & wr_full & ~pop);
    rd_d     = rd_valid ? mem[rp[AW-1:0]] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      ovf <= 1'b0;
    end else begin
      wp  <= wp_next;
      rp  <= rp_next;
      ovf <= ovf_next;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic entry_en;
    assign entry_en = push & (wp[AW-1:0] == AW'(i));

    sp1_ff #(
      .W(DW)
    ) u_entry (
      .clk(clk),
      .rst(rst),
      .en (entry_en),
      .d  (wr_d),
      .q  (mem[i])
    );
  end

endmodule

// File: tb/tb_sp1_wrq.sv
// Directed bench for sp1_wrq with a queue scoreboard of accepted words.
module tb_sp1_wrq;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_d;
  logic          wr_full;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_d;
  logic [AW:0]   count;
  logic          ovf;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [DW-1:0] sb[$];
  logic          ovf_exp = 1'b0;

  sp1_wrq #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_d    (wr_d),
    .wr_full (wr_full),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_d    (rd_d),
    .count   (count),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [DW-1:0] head;
    head = (sb.size() != 0) ? sb[0] : '0;
    chk({tag, "_count"}, 64'(count), 64'(sb.size()));
    chk({tag, "_valid"}, 64'(rd_valid), 64'(sb.size() != 0));
    chk({tag, "_full"}, 64'(wr_full), 64'(sb.size() == DEPTH));
    chk({tag, "_ovf"}, 64'(ovf), 64'(ovf_exp));
    chk({tag, "_rd_d"}, 64'(rd_d), 64'(head));
  endtask

  // Called just after an edge: drive inputs, score the pop/push, clock once, check.
  task automatic cycle(input string tag, input logic we, input logic [DW-1:0] d,
                       input logic rr);
    logic pop_m;
    logic full_m;
    wr_en    = we;
    wr_d     = d;
    rd_ready = rr;
    #1;
    full_m = (sb.size() == DEPTH);
    pop_m  = rr && (sb.size() != 0);
    if (pop_m) begin
      chk({tag, "_pop"}, 64'(rd_d), 64'(sb[0]));
      void'(sb.pop_front());
    end
    if (we === 1'b1) begin
      if (!full_m || pop_m) sb.push_back(d);
      else ovf_exp = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_d     = '0;
    rd_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("reset");

    // Single word, held, then popped.
    cycle("single_wr", 1'b1, 32'h1234_5678, 1'b0);
    chk("single_head", 64'(rd_d), 64'h1234_5678);
    cycle("single_rd", 1'b0, 32'h0, 1'b1);
    chk("single_empty", 64'(rd_valid), 64'h0);

    // Fill, overflow drop, drain in order.
    cycle("fill0", 1'b1, 32'hffff_ffff, 1'b0);
    cycle("fill1", 1'b1, 32'h0000_0000, 1'b0);
    cycle("fill2", 1'b1, 32'h1234_5678, 1'b0);
    cycle("fill3", 1'b1, 32'hcafe_cafe, 1'b0);
    chk("fill_full", 64'(wr_full), 64'h1);
    cycle("drop", 1'b1, 32'hbbbb_bbbb, 1'b0);
    chk("drop_ovf", 64'(ovf), 64'h1);
    chk("drop_head", 64'(rd_d), 64'hffff_ffff);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 32'h0, 1'b1);
    chk("drain_ovf_sticky", 64'(ovf), 64'h1);

    // Full with simultaneous pop and push.
    cycle("pf0", 1'b1, 32'h1111_1111, 1'b0);
    cycle("pf1", 1'b1, 32'h2222_2222, 1'b0);
    cycle("pf2", 1'b1, 32'h3333_3333, 1'b0);
    cycle("pf3", 1'b1, 32'h4444_4444, 1'b0);
    cycle("pf_swap", 1'b1, 32'hbeef_beef, 1'b1);
    chk("pf_count_stays", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) cycle("pf_drain", 1'b0, 32'h0, 1'b1);
    chk("pf_empty", 64'(rd_valid), 64'h0);

    // Streaming through pointer wrap, no bypass on the first word.
    for (int i = 1; i <= 10; i++) begin
      cycle("stream", 1'b1, DW'(i), 1'b1);
      chk("stream_cnt_le1", 64'(count <= 1), 64'h1);
    end
    cycle("stream_tail", 1'b0, 32'h0, 1'b1);

    // Unknown data with wr_en low leaves state alone.
    cycle("xdata_pre", 1'b1, 32'h5a5a_0001, 1'b0);
    cycle("xdata", 1'b0, 32'hxxxx_xxxx, 1'b0);
    chk("xdata_head", 64'(rd_d), 64'h5a5a_0001);

    // Mid-operation asynchronous reset.
    cycle("mr0", 1'b1, 32'h0a0a_0a0a, 1'b0);
    cycle("mr1", 1'b1, 32'h0b0b_0b0b, 1'b0);
    wr_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    ovf_exp = 1'b0;
    check_state("midrst");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle("post_rst", 1'b1, 32'h7777_0001, 1'b0);
    chk("post_rst_head", 64'(rd_d), 64'h7777_0001);
    cycle("post_rst_rd", 1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp1_wrq.md
# sp1_wrq

Write-side capture queue: the consumer end of the single-cycle `en`/`d` write strobe that drives `sp1_ff` registers. It accepts one word per cycle whenever `wr_en` is high and buffers up to `DEPTH` words in order. It presents them downstream through a `valid`/`ready` read handshake. It sits between a strobe-only producer (datapath write-back, test driver) and a consumer that may stall.

## Interface
- `DW`, 32: data width in bits.
- `DEPTH`, 4: entries; power of two, ≥ 2.
- `AW`, log2(`DEPTH`): pointer width; derived, not overridden.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `wr_en`  in  1  write strobe; one word per cycle when high.
- `wr_d`  in  DW  write data, sampled when `wr_en` = 1.
- `wr_full`  out  1  queue holds `DEPTH` words (advisory backpressure).
- `rd_valid`  out  1  head word available.
- `rd_ready`  in  1  consumer accepts the head word this cycle.
- `rd_d`  out  DW  head word; 0 when empty.
- `count`  out  AW+1  words held, 0..`DEPTH`.
- `ovf`  out  1  sticky: a write was dropped.

## Operation
- Storage: `DEPTH` entries, write pointer `wp`, read pointer `rp`, each AW+1 bits. The extra MSB distinguishes full from empty. `count` = `wp` − `rp` (mod 2^(AW+1)).
- Pop occurs when `rd_valid & rd_ready`. `rp` increments. `rd_ready` while empty is ignored.
- Push occurs when `wr_en & (!wr_full | pop)`. `wr_d` goes to entry `wp[AW-1:0]` and `wp` increments.
- Full plus pop in the same cycle: the write is accepted and `count` stays `DEPTH`.
- Full, no pop, `wr_en` = 1: the word is dropped. `ovf` sets on the next edge and stays set until `rst`. Contents are unchanged.
- Empty, `wr_en`, `rd_ready` in the same cycle: no bypass. The word is stored and `rd_valid` rises next cycle.
- Ordering is strict FIFO. Pointer wrap happens past entry `DEPTH`−1 without loss.
- `wr_en` = 0: `wr_d` is don't-care. Unknown `wr_d` has no effect on stored state.
- Outputs:
  - `rd_valid` = (`count` ≠ 0).
  - `wr_full` = (`count` == `DEPTH`).
  - `rd_d` = entry[`rp`] when valid, else all zeros.

## Timing
- Reset (async assert, release synchronous to `clk`): pointers 0, all entries 0, `ovf` 0. Hence `rd_valid` 0, `wr_full` 0, `count` 0, `rd_d` 0.
- `rst` mid-operation clears everything immediately. Buffered words are lost. A write in the release cycle is accepted at the first edge with `rst` low.
- Write-to-read latency is 1 cycle: word written at edge N appears on `rd_d` with `rd_valid` after edge N.
- Throughput is 1 push and 1 pop per cycle concurrently, sustained indefinitely when not full.
- `count`, `wr_full`, and `rd_valid` update only on clock edges. No combinational path from `wr_en`/`wr_d` to any output.
- Path from `rd_ready` to outputs: none. Pop takes effect at the edge.

## Structure
- `DW` default and any width macros go in the shared `sp1_common.h`. No block-private constants there.
- One sub-module, reused: each storage entry is an `sp1_ff #(DW)`. Its `en` is the push decode for that entry, `d` = `wr_d`, and `rst`/`clk` are shared. Pointers, `ovf`, and muxing are local.
- Target 150–250 lines of RTL.

## Test plan
- Reset/idle: hold `rst` 5 cycles, then release → `rd_valid` 0, `wr_full` 0, `count` 0, `rd_d` 0, `ovf` 0.
- Single word: write `32'h12345678` at cycle 1, `rd_ready` 0 → next cycle `rd_valid` 1, `rd_d` 12345678, `count` 1. Assert `rd_ready` → empty after one edge.
- Fill and overflow (`DEPTH` 4):
  - Write `ffffffff`, `00000000`, `12345678`, `cafecafe` → `wr_full` 1.
  - Write `bbbbbbbb` with `rd_ready` 0 → dropped, `ovf` 1.
  - Drain → four words in order; `ovf` stays 1.
- Full plus simultaneous pop/push: queue full, write `beefbeef` while `rd_ready` 1 → `count` stays 4. `beefbeef` emerges fifth after draining.
- Streaming wrap: `wr_en` and `rd_ready` both high for 10 cycles, data 1..10 → outputs 1..10, one per cycle after 1-cycle lag. `count` ≤ 1, no `ovf`.
- Reset mid-operation and X: write `xxxxxxxx` with `wr_en` 0 → no change. Fill 3 words, assert `rst` between edges → outputs 0 immediately; the next write after release is the head.
